// File: rtl/clock_pkg.sv
// Shared types, limits and wrap helpers for the clock/alarm datapath.
package clock_pkg;

   localparam int HR_W  = 5;
   localparam int MIN_W = 6;

   localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;
   localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

   typedef logic [1:0] state_t;
   localparam state_t IDLE   = 2'd0;
   localparam state_t RING   = 2'd1;
   localparam state_t SNOOZE = 2'd2;

   function automatic logic [HR_W-1:0] inc_hr(input logic [HR_W-1:0] h);
      return (h == HR_MAX) ? '0 : h + 1'b1;
   endfunction

   function automatic logic [MIN_W-1:0] inc_min(input logic [MIN_W-1:0] m);
      return (m == MIN_MAX) ? '0 : m + 1'b1;
   endfunction

endpackage

// File: rtl/alarm_set_ctrl_if.sv
// Button, time and alarm-status bundle between the panel logic and alarm_set_ctrl.
interface alarm_set_ctrl_if;
   import clock_pkg::*;

   logic              alarm_d;
   logic              alarm_en;
   logic              btn_hr;
   logic              btn_min;
   logic              btn_stop;
   logic              sec_tick;
   logic [HR_W-1:0]   cur_hr;
   logic [MIN_W-1:0]  cur_min;
   logic [MIN_W-1:0]  cur_sec;
   logic [HR_W-1:0]   alm_hr;
   logic [MIN_W-1:0]  alm_min;
   logic              ring;
   logic              snoozing;

   modport master (
      output alarm_d, alarm_en, btn_hr, btn_min, btn_stop, sec_tick,
             cur_hr, cur_min, cur_sec,
      input  alm_hr, alm_min, ring, snoozing
   );

   modport slave (
      input  alarm_d, alarm_en, btn_hr, btn_min, btn_stop, sec_tick,
             cur_hr, cur_min, cur_sec,
      output alm_hr, alm_min, ring, snoozing
   );

endinterface

// File: rtl/alarm_set_ctrl_edge_pulse.sv
// Registered rising-edge detector: one-cycle pulse, one cycle after the level rises.
module edge_pulse (
   input  logic cclk,
   input  logic clr,
   input  logic level,
   output logic pulse
);

   logic level_q;

   always_ff @(posedge cclk or posedge clr) begin
      if (clr) begin
         level_q <= 1'b0;
         pulse   <= 1'b0;
      end else begin
         level_q <= level;
         pulse   <= level & ~level_q;
      end
   end

endmodule

// File: rtl/alarm_set_ctrl.sv
// Alarm-time editing, alarm match and bounded ring control.
// Snooze support is compiled in when ALARM_SNOOZE_EN is defined.
module alarm_set_ctrl
   import clock_pkg::*;
#(
   parameter int RING_SECS = 60
`ifdef ALARM_SNOOZE_EN
   ,
   parameter int SNOOZE_MIN = 5
`endif
)(
   input logic             cclk,
   input logic             clr,
   alarm_set_ctrl_if.slave bus
);

   localparam logic [7:0] RING_LOAD = 8'(RING_SECS);

   logic             hr_ev, min_ev, stop_ev;
   logic [HR_W-1:0]  alm_hr_q;
   logic [MIN_W-1:0] alm_min_q;
   logic [HR_W-1:0]  tgt_hr;
   logic [MIN_W-1:0] tgt_min;
   logic             match, match_q, match_ev, expire;
   logic [7:0]       ring_cnt;
   logic             ring_q;
   state_t           state, state_nxt;

   edge_pulse u_hr_edge   (.cclk(cclk), .clr(clr), .level(bus.btn_hr),   .pulse(hr_ev));
   edge_pulse u_min_edge  (.cclk(cclk), .clr(clr), .level(bus.btn_min),  .pulse(min_ev));
   edge_pulse u_stop_edge (.cclk(cclk), .clr(clr), .level(bus.btn_stop), .pulse(stop_ev));

   // Hour and minute fields wrap independently; a minute rollover never carries.
   always_ff @(posedge cclk or posedge clr) begin
      if (clr) begin
         alm_hr_q  <= '0;
         alm_min_q <= '0;
      end else if (bus.alarm_d) begin
         if (hr_ev)  alm_hr_q  <= inc_hr(alm_hr_q);
         if (min_ev) alm_min_q <= inc_min(alm_min_q);
      end
   end

`ifdef ALARM_SNOOZE_EN
   localparam state_t STOP_DEST = SNOOZE;

   logic [HR_W-1:0]  snz_hr;
   logic [MIN_W-1:0] snz_min;
   logic [MIN_W:0]   min_sum;
   logic             snoozing_q;

   assign min_sum = {1'b0, bus.cur_min} + 7'(SNOOZE_MIN);

   // Snooze target is "now + SNOOZE_MIN", taken at the moment the ring is stopped.
   always_ff @(posedge cclk or posedge clr) begin
      if (clr) begin
         snz_hr     <= '0;
         snz_min    <= '0;
         snoozing_q <= 1'b0;
      end else begin
         snoozing_q <= (state_nxt == SNOOZE);
         if (state == RING && state_nxt == SNOOZE) begin
            if (min_sum > {1'b0, MIN_MAX}) begin
               snz_min <= MIN_W'(min_sum - 7'd60);
               snz_hr  <= inc_hr(bus.cur_hr);
            end else begin
               snz_min <= min_sum[MIN_W-1:0];
               snz_hr  <= bus.cur_hr;
            end
         end
      end
   end

   assign tgt_hr       = (state == SNOOZE) ? snz_hr  : alm_hr_q;
   assign tgt_min      = (state == SNOOZE) ? snz_min : alm_min_q;
   assign bus.snoozing = snoozing_q;
`else
   localparam state_t STOP_DEST = IDLE;

   assign tgt_hr       = alm_hr_q;
   assign tgt_min      = alm_min_q;
   assign bus.snoozing = 1'b0;
`endif

   assign match    = (bus.cur_hr == tgt_hr) && (bus.cur_min == tgt_min) && (bus.cur_sec == '0);
   assign match_ev = match & ~match_q;
   assign expire   = bus.sec_tick && (ring_cnt == 8'd1);

   // Disarm overrides everything; a stop outranks a simultaneous expiry.
   always_comb begin
      state_nxt = state;
      if (!bus.alarm_en) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (match_ev) state_nxt = RING;
            RING:    if (stop_ev)  state_nxt = STOP_DEST;
                     else if (expire) state_nxt = IDLE;
`ifdef ALARM_SNOOZE_EN
            SNOOZE:  if (match_ev) state_nxt = RING;
`endif
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge cclk or posedge clr) begin
      if (clr) begin
         state    <= IDLE;
         ring_q   <= 1'b0;
         match_q  <= 1'b0;
         ring_cnt <= '0;
      end else begin
         state   <= state_nxt;
         ring_q  <= (state_nxt == RING);
         match_q <= match;
         if (state != RING && state_nxt == RING)
            ring_cnt <= RING_LOAD;
         else if (state_nxt != RING)
            ring_cnt <= '0;
         else if (bus.sec_tick)
            ring_cnt <= ring_cnt - 1'b1;
      end
   end

   assign bus.alm_hr  = alm_hr_q;
   assign bus.alm_min = alm_min_q;
   assign bus.ring    = ring_q;

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Scoreboard bench for alarm_set_ctrl: directed scenarios plus random stimulus against a behavioural model.
module tb_alarm_set_ctrl;
   import clock_pkg::*;

   localparam int RING_SECS = 60;
`ifdef ALARM_SNOOZE_EN
   localparam bit SNZ_EN     = 1'b1;
   localparam int SNOOZE_MIN = 5;
`else
   localparam bit SNZ_EN     = 1'b0;
   localparam int SNOOZE_MIN = 0;
`endif

   logic cclk = 1'b0;
   logic clr;

   alarm_set_ctrl_if bus();

   alarm_set_ctrl #(.RING_SECS(RING_SECS)) dut (
      .cclk(cclk),
      .clr (clr),
      .bus (bus)
   );

   always #5 cclk = ~cclk;

   typedef struct {
      int hr;
      int mn;
      bit ring;
      bit snz;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   passes = 0;

   bit s_alarm_d, s_alarm_en, s_btn_hr, s_btn_min, s_btn_stop, s_sec_tick;
   int s_cur_hr, s_cur_min, s_cur_sec;

   int m_alm_hr, m_alm_min, m_left, m_snz_hr, m_snz_min;
   bit m_ringing, m_snoozed, m_match_last;
   bit m_prev_hr, m_prev_min, m_prev_stop;
   bit m_ev_hr, m_ev_min, m_ev_stop;

   task automatic check_output(input string name, input int actual, input int expected);
      checks++;
      if (actual == expected) passes++;
      else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
   endtask

   task automatic model_reset();
      m_alm_hr = 0; m_alm_min = 0; m_left = 0; m_snz_hr = 0; m_snz_min = 0;
      m_ringing = 0; m_snoozed = 0; m_match_last = 0;
      m_prev_hr = 0; m_prev_min = 0; m_prev_stop = 0;
      m_ev_hr = 0; m_ev_min = 0; m_ev_stop = 0;
   endtask

   // One clock of behaviour: button edges become usable one clock after the rise.
   task automatic model_step();
      int   t_hr, t_min, total;
      bit   hit, fire;
      exp_t e;
      t_hr  = m_snoozed ? m_snz_hr  : m_alm_hr;
      t_min = m_snoozed ? m_snz_min : m_alm_min;
      hit   = (s_cur_hr == t_hr) && (s_cur_min == t_min) && (s_cur_sec == 0);
      fire  = hit && !m_match_last;
      m_match_last = hit;
      if (!s_alarm_en) begin
         m_ringing = 0;
         m_snoozed = 0;
      end else if (m_ringing) begin
         if (m_ev_stop) begin
            m_ringing = 0;
            if (SNZ_EN) begin
               total     = s_cur_hr * 60 + s_cur_min + SNOOZE_MIN;
               m_snz_hr  = (total / 60) % 24;
               m_snz_min = total % 60;
               m_snoozed = 1;
            end
         end else if (s_sec_tick) begin
            m_left--;
            if (m_left == 0) m_ringing = 0;
         end
      end else if (fire) begin
         m_ringing = 1;
         m_snoozed = 0;
         m_left    = RING_SECS;
      end
      if (s_alarm_d) begin
         if (m_ev_hr)  m_alm_hr  = (m_alm_hr + 1) % 24;
         if (m_ev_min) m_alm_min = (m_alm_min + 1) % 60;
      end
      m_ev_hr   = s_btn_hr   && !m_prev_hr;   m_prev_hr   = s_btn_hr;
      m_ev_min  = s_btn_min  && !m_prev_min;  m_prev_min  = s_btn_min;
      m_ev_stop = s_btn_stop && !m_prev_stop; m_prev_stop = s_btn_stop;
      e.hr = m_alm_hr; e.mn = m_alm_min; e.ring = m_ringing; e.snz = m_snoozed;
      sb_q.push_back(e);
   endtask

   task automatic drive_inputs();
      bus.alarm_d  = s_alarm_d;
      bus.alarm_en = s_alarm_en;
      bus.btn_hr   = s_btn_hr;
      bus.btn_min  = s_btn_min;
      bus.btn_stop = s_btn_stop;
      bus.sec_tick = s_sec_tick;
      bus.cur_hr   = 5'(s_cur_hr);
      bus.cur_min  = 6'(s_cur_min);
      bus.cur_sec  = 6'(s_cur_sec);
   endtask

   task automatic apply_stimulus(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge cclk);
         drive_inputs();
         model_step();
      end
   endtask

   task automatic press(input int sel);
      case (sel)
         0:       s_btn_hr   = 1'b1;
         1:       s_btn_min  = 1'b1;
         default: s_btn_stop = 1'b1;
      endcase
      apply_stimulus(1);
      s_btn_hr = 1'b0; s_btn_min = 1'b0; s_btn_stop = 1'b0;
      apply_stimulus(1);
   endtask

   task automatic set_alarm(input int h, input int m);
      s_alarm_d = 1'b1;
      for (int i = 0; i < 30 && m_alm_hr != h; i++)  press(0);
      for (int i = 0; i < 70 && m_alm_min != m; i++) press(1);
      s_alarm_d = 1'b0;
      apply_stimulus(2);
   endtask

   task automatic set_time(input int h, input int m, input int s);
      s_cur_hr = h; s_cur_min = m; s_cur_sec = s;
   endtask

   task automatic settle();
      @(posedge cclk);
      #2;
   endtask

   task automatic start_ring(input int h, input int m);
      set_time(h, m, 59);
      apply_stimulus(2);
      set_time(h, m, 0);
      apply_stimulus(2);
   endtask

   task automatic rearm();
      s_alarm_en = 1'b0;
      apply_stimulus(2);
      s_alarm_en = 1'b1;
      apply_stimulus(1);
   endtask

   // Monitor: every clock with a pending expectation is compared just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge cclk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_output("sb_alm_hr",   int'(bus.alm_hr),   e.hr);
            check_output("sb_alm_min",  int'(bus.alm_min),  e.mn);
            check_output("sb_ring",     int'(bus.ring),     int'(e.ring));
            check_output("sb_snoozing", int'(bus.snoozing), int'(e.snz));
         end
      end
   end

   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      clr = 1'b1;
      s_alarm_d = 0; s_alarm_en = 0; s_btn_hr = 0; s_btn_min = 0; s_btn_stop = 0; s_sec_tick = 0;
      set_time(0, 0, 0);
      drive_inputs();
      model_reset();
      #1;
      check_output("reset_alm_hr",   int'(bus.alm_hr),   0);
      check_output("reset_alm_min",  int'(bus.alm_min),  0);
      check_output("reset_ring",     int'(bus.ring),     0);
      check_output("reset_snoozing", int'(bus.snoozing), 0);
      #11;
      clr = 1'b0;

      $display("[TB] edit and wrap");
      s_alarm_d = 1'b1;
      s_btn_hr  = 1'b1;
      apply_stimulus(100);
      s_btn_hr  = 1'b0;
      apply_stimulus(2);
      settle();
      check_output("hold_one_inc", int'(bus.alm_hr), 1);
      for (int i = 0; i < 23; i++) press(0);
      apply_stimulus(1);
      settle();
      check_output("hr_wrap", int'(bus.alm_hr), 0);
      for (int i = 0; i < 59; i++) press(1);
      apply_stimulus(1);
      settle();
      check_output("min_at_max", int'(bus.alm_min), 59);
      press(1);
      apply_stimulus(1);
      settle();
      check_output("min_wrap",     int'(bus.alm_min), 0);
      check_output("min_no_carry", int'(bus.alm_hr),  0);

      $display("[TB] edits blocked");
      s_alarm_d = 1'b0;
      for (int i = 0; i < 3; i++) press(1);
      apply_stimulus(1);
      settle();
      check_output("edit_blocked", int'(bus.alm_min), 0);

      $display("[TB] ring and timeout");
      set_alarm(7, 30);
      s_alarm_en = 1'b1;
      set_time(7, 29, 59);
      apply_stimulus(3);
      set_time(7, 30, 0);
      apply_stimulus(1);
      settle();
      check_output("ring_on_match", int'(bus.ring), 1);
      for (int i = 0; i < RING_SECS - 1; i++) begin
         s_sec_tick = 1'b1; apply_stimulus(1);
         s_sec_tick = 1'b0; apply_stimulus(2);
      end
      settle();
      check_output("ring_before_last_tick", int'(bus.ring), 1);
      s_sec_tick = 1'b1; apply_stimulus(1);
      s_sec_tick = 1'b0; apply_stimulus(1);
      settle();
      check_output("ring_timeout", int'(bus.ring), 0);
      apply_stimulus(10);
      settle();
      check_output("no_retrigger", int'(bus.ring), 0);

      $display("[TB] stop and disarm");
      start_ring(7, 30);
      s_btn_stop = 1'b1;
      apply_stimulus(1);
      settle();
      check_output("stop_lat1", int'(bus.ring), 1);
      apply_stimulus(1);
      settle();
      check_output("stop_lat2", int'(bus.ring), 0);
      s_btn_stop = 1'b0;
      rearm();
      start_ring(7, 30);
      s_alarm_en = 1'b0;
      apply_stimulus(1);
      settle();
      check_output("disarm", int'(bus.ring), 0);
      s_alarm_en = 1'b1;
      apply_stimulus(2);

`ifdef ALARM_SNOOZE_EN
      $display("[TB] snooze");
      set_alarm(23, 58);
      start_ring(23, 58);
      set_time(23, 58, 30);
      press(2);
      settle();
      check_output("snooze_set",  int'(bus.snoozing), 1);
      check_output("snooze_ring", int'(bus.ring),     0);
      start_ring(0, 3);
      settle();
      check_output("snooze_fire_ring", int'(bus.ring),     1);
      check_output("snooze_fire_snz",  int'(bus.snoozing), 0);
      rearm();
`endif

      $display("[TB] random");
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 5) == 0)  s_btn_hr   = !s_btn_hr;
         if ($urandom_range(0, 5) == 0)  s_btn_min  = !s_btn_min;
         if ($urandom_range(0, 39) == 0) s_btn_stop = !s_btn_stop;
         if ($urandom_range(0, 49) == 0) s_alarm_d  = !s_alarm_d;
         s_alarm_en = ($urandom_range(0, 79) != 0);
         s_sec_tick = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 2))
               0:       begin s_cur_hr = m_alm_hr; s_cur_min = m_alm_min; end
               1:       begin s_cur_hr = m_snz_hr; s_cur_min = m_snz_min; end
               default: begin s_cur_hr = $urandom_range(0, 23); s_cur_min = $urandom_range(0, 59); end
            endcase
            s_cur_sec = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 59);
         end
         apply_stimulus(1);
      end
      s_btn_hr = 0; s_btn_min = 0; s_btn_stop = 0; s_alarm_d = 0; s_sec_tick = 0;
      apply_stimulus(3);

      $display("[TB] reset mid-ring");
      rearm();
      set_alarm(5, 15);
      start_ring(5, 15);
      settle();
      check_output("pre_reset_ring", int'(bus.ring), 1);
      #1;
      clr = 1'b1;
      #1;
      check_output("clr_ring",    int'(bus.ring),    0);
      check_output("clr_alm_hr",  int'(bus.alm_hr),  0);
      check_output("clr_alm_min", int'(bus.alm_min), 0);
      model_reset();
      repeat (2) @(posedge cclk);
      #3;
      clr = 1'b0;
      apply_stimulus(5);

      repeat (3) @(posedge cclk);
      #2;
      check_output("queue_drained", sb_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
